dmem_sram_responder: RTL and testbench

- Responder end of the core's data memory access bus (dmem_*).
- Accepts load/store requests issued by the core and services them from an internal byte-writable SRAM array with a configurable number of wait states.
- Returns dmem_ack or dmem_err, and flags misaligned and out-of-range accesses.
- Used as the data-side memory model in core-level simulation and formal harnesses, and as a small tightly-coupled data RAM.

---
 rtl/dmem_sram_responder.sv | 169 ++++++++++++++++
 tb/tb_dmem_sram_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sram_responder.sv
// Responder for the core data-memory bus: byte-writable SRAM with wait states,
// alignment and range fault reporting.
//
// dmem_size encoding: 2'b00 BYTE, 2'b01 HWORD, 2'b10 WORD, 2'b11 DWORD (unsupported).
// Only XLEN = 32 is supported; WAIT_STATES must lie in 0..15.
module dmem_sram_responder #(
    parameter int unsigned      XLEN        = 32,
    parameter int unsigned      ADDR_BITS   = 10,
    parameter int unsigned      WAIT_STATES = 1,
    parameter logic [XLEN-1:0]  BASE_ADDR   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dmem_req,
    input  logic [XLEN-1:0]  dmem_adr,
    input  logic             dmem_we,
    input  logic [1:0]       dmem_size,
    input  logic [XLEN-1:0]  dmem_d,
    output logic [XLEN-1:0]  dmem_q,
    output logic             dmem_ack,
    output logic             dmem_err,
    output logic             dmem_misaligned,
    output logic             dmem_page_fault
);

    localparam int unsigned DEPTH  = 2 ** ADDR_BITS;
    localparam int unsigned LANES  = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HWORD = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP_OK,
        ST_RESP_ERR
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   we_q;
    logic [LANES-1:0]       be_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [XLEN-1:0]        wdata_q;
    logic [XLEN-1:0]        q_q;
    logic                   ack_q;
    logic                   err_q;
    logic                   mis_q;

    logic [XLEN-1:0]        mem_q [DEPTH];

    logic [XLEN-1:0]        off_c;
    logic [ADDR_BITS-1:0]   idx_c;
    logic [LANES-1:0]       be_c;
    logic                   misaligned_c;
    logic                   out_of_range_c;

    // Classify the request on the bus: alignment, range, byte lanes and word index.
    always_comb begin
        off_c          = dmem_adr - BASE_ADDR;
        idx_c          = off_c[ADDR_BITS+1:2];
        be_c           = '0;
        misaligned_c   = 1'b0;
        unique case (dmem_size)
            SIZE_BYTE: begin
                be_c = 4'b0001 << dmem_adr[1:0];
            end
            SIZE_HWORD: begin
                be_c         = dmem_adr[1] ? 4'b1100 : 4'b0011;
                misaligned_c = dmem_adr[0];
            end
            SIZE_WORD: begin
                be_c         = 4'b1111;
                misaligned_c = (dmem_adr[1:0] != 2'b00);
            end
            default: begin
                misaligned_c = 1'b1;
            end
        endcase
        // Full-width difference so a wrapped offset is never mistaken for in-range.
        out_of_range_c = (dmem_adr < BASE_ADDR) || ((off_c >> 2) >= XLEN'(DEPTH));
    end

    // Transaction FSM with registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            q_q     <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            mis_q <= 1'b0;
            q_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (dmem_req) begin
                        we_q    <= dmem_we;
                        be_q    <= be_c;
                        idx_q   <= idx_c;
                        wdata_q <= dmem_d;
                        if (misaligned_c || out_of_range_c) begin
                            state_q <= ST_RESP_ERR;
                            err_q   <= 1'b1;
                            mis_q   <= misaligned_c;
                        end else if (WAIT_STATES != 0) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_W'(1);
                        end else begin
                            state_q <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_W'(WAIT_STATES)) begin
                        state_q <= ST_ACCESS;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_ACCESS: begin
                    state_q <= ST_RESP_OK;
                    ack_q   <= 1'b1;
                    if (!we_q) begin
                        q_q <= mem_q[idx_q];
                    end
                end
                ST_RESP_OK: begin
                    state_q <= ST_IDLE;
                end
                ST_RESP_ERR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte-lane write into the array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_ACCESS && we_q) begin
            for (int unsigned b = 0; b < LANES; b++) begin
                if (be_q[b]) begin
                    mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    assign dmem_q          = q_q;
    assign dmem_ack        = ack_q;
    assign dmem_err        = err_q;
    assign dmem_misaligned = mis_q;
    assign dmem_page_fault = 1'b0;

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Directed bench: instance A (WAIT_STATES=1, BASE 0), instance B (WAIT_STATES=0, BASE 'h2000).
module tb_dmem_sram_responder;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_a = 1'b0, we_a = 1'b0;
    logic [1:0]  size_a = 2'b00;
    logic [31:0] adr_a = '0, d_a = '0;
    logic [31:0] q_a;
    logic        ack_a, err_a, mis_a, pf_a;

    logic        req_b = 1'b0, we_b = 1'b0;
    logic [1:0]  size_b = 2'b00;
    logic [31:0] adr_b = '0, d_b = '0;
    logic [31:0] q_b;
    logic        ack_b, err_b, mis_b, pf_b;

    logic        sel = 1'b0;
    logic        ack_m, err_m, mis_m;
    logic [31:0] q_m;
    assign ack_m = sel ? ack_b : ack_a;
    assign err_m = sel ? err_b : err_a;
    assign mis_m = sel ? mis_b : mis_a;
    assign q_m   = sel ? q_b   : q_a;

    int checks = 0;
    int errors = 0;

    dmem_sram_responder #(.XLEN(32), .ADDR_BITS(10), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_dut_a (
        .clk(clk), .rst(rst), .dmem_req(req_a), .dmem_adr(adr_a), .dmem_we(we_a),
        .dmem_size(size_a), .dmem_d(d_a), .dmem_q(q_a), .dmem_ack(ack_a), .dmem_err(err_a),
        .dmem_misaligned(mis_a), .dmem_page_fault(pf_a)
    );

    dmem_sram_responder #(.XLEN(32), .ADDR_BITS(10), .WAIT_STATES(0), .BASE_ADDR(32'h2000)) u_dut_b (
        .clk(clk), .rst(rst), .dmem_req(req_b), .dmem_adr(adr_b), .dmem_we(we_b),
        .dmem_size(size_b), .dmem_d(d_b), .dmem_q(q_b), .dmem_ack(ack_b), .dmem_err(err_b),
        .dmem_misaligned(mis_b), .dmem_page_fault(pf_b)
    );

    // Issue one request (called just after a rising edge) and report what came back.
    // lat = rising edges from request to the response cycle, -1 on timeout.
    task automatic bus_txn(input logic s, input logic we, input logic [1:0] size,
                           input logic [31:0] adr, input logic [31:0] d,
                           output int lat, output logic ack, output logic err,
                           output logic mis, output logic [31:0] q);
        bit done = 1'b0;
        sel = s;
        if (s) begin
            req_b = 1'b1; we_b = we; size_b = size; adr_b = adr; d_b = d;
        end else begin
            req_a = 1'b1; we_a = we; size_a = size; adr_a = adr; d_a = d;
        end
        lat = 0; ack = 1'b0; err = 1'b0; mis = 1'b0; q = '0;
        while (!done && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ack_m || err_m) begin
                done = 1'b1;
                ack = ack_m; err = err_m; mis = mis_m; q = q_m;
            end
        end
        if (!done) lat = -1;
        req_a = 1'b0;
        req_b = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ack_a, err_a, mis_a, pf_a} !== 4'b0000 || q_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_a: ack/err/mis/pf=%b%b%b%b q=%h want 0000 q=0", ack_a, err_a, mis_a, pf_a, q_a);
        end
        checks++;
        if ({ack_b, err_b, mis_b, pf_b} !== 4'b0000 || q_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_b: ack/err/mis/pf=%b%b%b%b q=%h want 0000 q=0", ack_b, err_b, mis_b, pf_b, q_b);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_word_store_load();
        int lat; logic ack, err, mis; logic [31:0] q;
        bus_txn(1'b0, 1'b1, SZ_W, 32'h10, 32'hDEADBEEF, lat, ack, err, mis, q);
        checks++;
        if (lat !== 3 || ack !== 1'b1 || err !== 1'b0 || q !== 32'h0) begin
            errors++;
            $display("FAIL st_word: lat=%0d ack=%b err=%b q=%h want lat=3 ack=1 err=0 q=0", lat, ack, err, q);
        end
        bus_txn(1'b0, 1'b0, SZ_W, 32'h10, 32'h0, lat, ack, err, mis, q);
        checks++;
        if (lat !== 3 || ack !== 1'b1 || err !== 1'b0 || q !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL ld_word: lat=%0d ack=%b err=%b q=%h want lat=3 ack=1 err=0 q=deadbeef", lat, ack, err, q);
        end
    endtask

    task automatic test_byte_lanes();
        int lat; logic ack, err, mis; logic [31:0] q;
        bus_txn(1'b0, 1'b1, SZ_W, 32'h10, 32'h11223344, lat, ack, err, mis, q);
        // Store data is lane-aligned: byte at offset 1 travels on bits 15:8.
        bus_txn(1'b0, 1'b1, SZ_B, 32'h11, 32'h0000AA00, lat, ack, err, mis, q);
        checks++;
        if (lat !== 3 || ack !== 1'b1) begin
            errors++;
            $display("FAIL st_byte: lat=%0d ack=%b want lat=3 ack=1", lat, ack);
        end
        bus_txn(1'b0, 1'b0, SZ_W, 32'h10, 32'h0, lat, ack, err, mis, q);
        checks++;
        if (q !== 32'h1122AA44 || ack !== 1'b1) begin
            errors++;
            $display("FAIL ld_after_byte: q=%h ack=%b want q=1122aa44 ack=1", q, ack);
        end
        bus_txn(1'b0, 1'b1, SZ_H, 32'h12, 32'hBEEF0000, lat, ack, err, mis, q);
        bus_txn(1'b0, 1'b1, SZ_B, 32'h13, 32'h77000000, lat, ack, err, mis, q);
        bus_txn(1'b0, 1'b0, SZ_W, 32'h10, 32'h0, lat, ack, err, mis, q);
        checks++;
        if (q !== 32'h77EFAA44) begin
            errors++;
            $display("FAIL ld_after_hword_byte3: q=%h want 77efaa44", q);
        end
    endtask

    task automatic test_misaligned();
        int lat; logic ack, err, mis; logic [31:0] q;
        bus_txn(1'b0, 1'b0, SZ_H, 32'h13, 32'h0, lat, ack, err, mis, q);
        checks++;
        if (lat !== 1 || ack !== 1'b0 || err !== 1'b1 || mis !== 1'b1 || q !== 32'h0) begin
            errors++;
            $display("FAIL mis_hword: lat=%0d ack=%b err=%b mis=%b q=%h want 1 0 1 1 0", lat, ack, err, mis, q);
        end
        bus_txn(1'b0, 1'b1, SZ_W, 32'h12, 32'hFFFFFFFF, lat, ack, err, mis, q);
        checks++;
        if (lat !== 1 || err !== 1'b1 || mis !== 1'b1) begin
            errors++;
            $display("FAIL mis_word_store: lat=%0d err=%b mis=%b want 1 1 1", lat, err, mis);
        end
        bus_txn(1'b0, 1'b1, SZ_D, 32'h10, 32'hFFFFFFFF, lat, ack, err, mis, q);
        checks++;
        if (lat !== 1 || err !== 1'b1 || mis !== 1'b1 || ack !== 1'b0) begin
            errors++;
            $display("FAIL dword: lat=%0d ack=%b err=%b mis=%b want 1 0 1 1", lat, ack, err, mis);
        end
        bus_txn(1'b0, 1'b0, SZ_W, 32'h10, 32'h0, lat, ack, err, mis, q);
        checks++;
        if (q !== 32'h77EFAA44) begin
            errors++;
            $display("FAIL mem_unchanged_after_faults: q=%h want 77efaa44", q);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic ack, err, mis; logic [31:0] q;
        bus_txn(1'b0, 1'b0, SZ_W, 32'h1000, 32'h0, lat, ack, err, mis, q);
        checks++;
        if (lat !== 1 || ack !== 1'b0 || err !== 1'b1 || mis !== 1'b0) begin
            errors++;
            $display("FAIL oor_a_1000: lat=%0d ack=%b err=%b mis=%b want 1 0 1 0", lat, ack, err, mis);
        end
        bus_txn(1'b0, 1'b1, SZ_W, 32'hFFC, 32'h0C0FFEE0, lat, ack, err, mis, q);
        bus_txn(1'b0, 1'b0, SZ_W, 32'hFFC, 32'h0, lat, ack, err, mis, q);
        checks++;
        if (lat !== 3 || ack !== 1'b1 || q !== 32'h0C0FFEE0) begin
            errors++;
            $display("FAIL last_word: lat=%0d ack=%b q=%h want 3 1 0c0ffee0", lat, ack, q);
        end
        bus_txn(1'b0, 1'b0, SZ_W, 32'hFFFFFFFC, 32'h0, lat, ack, err, mis, q);
        checks++;
        if (lat !== 1 || err !== 1'b1 || mis !== 1'b0) begin
            errors++;
            $display("FAIL oor_a_top: lat=%0d err=%b mis=%b want 1 1 0", lat, err, mis);
        end
        bus_txn(1'b1, 1'b0, SZ_W, 32'h1FFC, 32'h0, lat, ack, err, mis, q);
        checks++;
        if (lat !== 1 || ack !== 1'b0 || err !== 1'b1 || mis !== 1'b0) begin
            errors++;
            $display("FAIL oor_b_below_base: lat=%0d ack=%b err=%b mis=%b want 1 0 1 0", lat, ack, err, mis);
        end
        bus_txn(1'b1, 1'b0, SZ_W, 32'h3000, 32'h0, lat, ack, err, mis, q);
        checks++;
        if (lat !== 1 || err !== 1'b1 || mis !== 1'b0) begin
            errors++;
            $display("FAIL oor_b_above: lat=%0d err=%b mis=%b want 1 1 0", lat, err, mis);
        end
        bus_txn(1'b1, 1'b0, SZ_H, 32'h1001, 32'h0, lat, ack, err, mis, q);
        checks++;
        if (lat !== 1 || err !== 1'b1 || mis !== 1'b1) begin
            errors++;
            $display("FAIL priority_mis_over_range: lat=%0d err=%b mis=%b want 1 1 1", lat, err, mis);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic ack, err, mis; logic [31:0] q;
        int n = 0;
        int cyc = 0;
        int ack_cyc [3];
        logic [31:0] ack_q [3];
        bit saw_err = 1'b0;
        bus_txn(1'b1, 1'b1, SZ_W, 32'h2000, 32'h11111111, lat, ack, err, mis, q);
        checks++;
        if (lat !== 2 || ack !== 1'b1) begin
            errors++;
            $display("FAIL b_store_lat: lat=%0d ack=%b want 2 1", lat, ack);
        end
        bus_txn(1'b1, 1'b1, SZ_W, 32'h2004, 32'h22222222, lat, ack, err, mis, q);
        bus_txn(1'b1, 1'b1, SZ_W, 32'h2008, 32'h33333333, lat, ack, err, mis, q);
        for (int i = 0; i < 3; i++) begin
            ack_cyc[i] = -1;
            ack_q[i]   = '0;
        end
        sel = 1'b1;
        req_b = 1'b1; we_b = 1'b0; size_b = SZ_W; adr_b = 32'h2000; d_b = '0;
        while (n < 3 && cyc < 30) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (err_b) saw_err = 1'b1;
            if (ack_b) begin
                ack_cyc[n] = cyc;
                ack_q[n]   = q_b;
                n++;
                if (n == 3) req_b = 1'b0;
                else adr_b = 32'h2000 + 32'(4 * n);
            end
        end
        req_b = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ack_cyc[0] !== 2 || ack_cyc[1] !== 5 || ack_cyc[2] !== 8 || saw_err) begin
            errors++;
            $display("FAIL b2b_timing: acks at %0d %0d %0d err=%b want 2 5 8 err=0",
                     ack_cyc[0], ack_cyc[1], ack_cyc[2], saw_err);
        end
        checks++;
        if (ack_q[0] !== 32'h11111111 || ack_q[1] !== 32'h22222222 || ack_q[2] !== 32'h33333333) begin
            errors++;
            $display("FAIL b2b_data: q=%h %h %h want 11111111 22222222 33333333", ack_q[0], ack_q[1], ack_q[2]);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic ack, err, mis; logic [31:0] q;
        int stray = 0;
        bus_txn(1'b0, 1'b1, SZ_W, 32'h20, 32'h0, lat, ack, err, mis, q);
        sel = 1'b0;
        req_a = 1'b1; we_a = 1'b1; size_a = SZ_W; adr_a = 32'h20; d_a = 32'h5A5A5A5A;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        req_a = 1'b0;
        #1;
        checks++;
        if ({ack_a, err_a, mis_a, pf_a} !== 4'b0000 || q_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: ack/err/mis/pf=%b%b%b%b q=%h want 0000 q=0", ack_a, err_a, mis_a, pf_a, q_a);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ack_a || err_a) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_resp: responses=%0d want 0", stray);
        end
        @(posedge clk);
        #1;
        bus_txn(1'b0, 1'b0, SZ_W, 32'h20, 32'h0, lat, ack, err, mis, q);
        checks++;
        if (lat !== 3 || ack !== 1'b1 || q !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_no_write: lat=%0d ack=%b q=%h want 3 1 0", lat, ack, q);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_word_store_load();
        test_byte_lanes();
        test_misaligned();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
